reg_writeback_queue: RTL and testbench

// - Write-side driver for the 32x32 register file: buffers results from the ALU and load paths in an in-order FIFO.
// - Retires at most one entry per cycle onto the regfile write port (regwen/addrD/dataD).
// - Outputs change on posedge clk; the regfile samples them on the following negedge, so they are stable when used.
// - Publishes a per-register pending vector so decode can stall on RAW hazards against queued writes.

---
 rtl/reg_writeback_queue.sv | 192 +++++++++++++++++++
 tb/tb_reg_writeback_queue.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
// In-order write-back FIFO that feeds the register file write port.
// It collects results from the load path (mem_*) and the ALU path (alu_*),
// and it retires at most one entry per cycle onto regwen/addrD/dataD.
// It also publishes a per-register pending vector, so decode can stall on RAW hazards.
//
// Optional feature: define WB_FORWARD_EN to add forwarding read ports
// (fwd_addrA/B -> fwd_hitA/B, fwd_dataA/B). These ports return the youngest
// queued or in-flight value for a register. With the macro undefined the ports
// do not exist, and consumers stall on pending instead.

module reg_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  output logic            regwen,
  output logic [4:0]      addrD,
  output logic [XLEN-1:0] dataD,
`ifdef WB_FORWARD_EN
  input  logic [4:0]      fwd_addrA,
  input  logic [4:0]      fwd_addrB,
  output logic            fwd_hitA,
  output logic            fwd_hitB,
  output logic [XLEN-1:0] fwd_dataA,
  output logic [XLEN-1:0] fwd_dataB,
`endif
  output logic [31:0]     pending
);

  // Pointer width, and count width (count must be able to hold DEPTH itself).
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] depthC = CW'(DEPTH);

  genvar gi;

  // FIFO storage. It is read combinationally by the hazard and forwarding scans.
  logic [4:0]      rdMem   [DEPTH];
  logic [XLEN-1:0] dataMem [DEPTH];

  logic [CW-1:0] countReg;
  logic [CW-1:0] countNext;
  logic [PW-1:0] headReg;
  logic [PW-1:0] tailReg;

  logic [CW-1:0] freeSlots;
  logic          memPush;
  logic          aluPush;
  logic [PW-1:0] aluSlot;
  logic [CW-1:0] pushCount;
  logic          popNow;

  // Entries listed by age: index 0 is the head (oldest) and index DEPTH-1 is the youngest slot.
  logic [PW-1:0] ageIdx   [DEPTH];
  logic          ageValid [DEPTH];

  logic [31:0]   pendingVec;

  // Free space uses the registered count only, so a pop in the same cycle never makes room early.
  assign freeSlots = depthC - countReg;

  // When mem is also valid, it claims the first free slot, so alu needs a second one.
  assign mem_ready = rst_n && (freeSlots >= CW'(1));
  assign alu_ready = rst_n && (mem_valid ? (freeSlots >= CW'(2)) : (freeSlots >= CW'(1)));

  // A handshake with rd==0 completes, but it never occupies a slot.
  assign memPush   = mem_valid && mem_ready && (mem_rd != 5'd0);
  assign aluPush   = alu_valid && alu_ready && (alu_rd != 5'd0);

  // mem is older, so it takes the tail slot and alu goes behind it.
  assign aluSlot   = tailReg + PW'(memPush);
  assign pushCount = CW'(memPush) + CW'(aluPush);

  // The pop decision uses the count before this edge's pushes.
  assign popNow    = rst_n && (countReg != '0);
  assign countNext = countReg + pushCount - CW'(popNow);

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gAge
      assign ageIdx[gi]   = headReg + PW'(gi);
      assign ageValid[gi] = (CW'(gi) < countReg);
    end
  endgenerate

  // Payload writes. Storage is not reset, because the count/pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (memPush) begin
      rdMem[tailReg]   <= mem_rd;
      dataMem[tailReg] <= mem_data;
    end
    if (aluPush) begin
      rdMem[aluSlot]   <= alu_rd;
      dataMem[aluSlot] <= alu_data;
    end
  end

  // Occupancy and pointer bookkeeping. Pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      countReg <= '0;
      headReg  <= '0;
      tailReg  <= '0;
    end else begin
      countReg <= countNext;
      tailReg  <= tailReg + PW'(pushCount);
      if (popNow) begin
        headReg <= headReg + PW'(1);
      end
    end
  end

  // Write-port register. The head moves here on every pop; otherwise addr/data hold and regwen drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regwen <= 1'b0;
      addrD  <= 5'd0;
      dataD  <= '0;
    end else if (popNow) begin
      regwen <= 1'b1;
      addrD  <= rdMem[headReg];
      dataD  <= dataMem[headReg];
    end else begin
      regwen <= 1'b0;
    end
  end

  // Hazard vector: every live FIFO destination, plus the write currently on the port.
  always_comb begin
    pendingVec = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ageValid[k]) begin
        pendingVec[rdMem[ageIdx[k]]] = 1'b1;
      end
    end
    if (regwen) begin
      pendingVec[addrD] = 1'b1;
    end
    pendingVec[0] = 1'b0;
  end

  assign pending = pendingVec;

`ifdef WB_FORWARD_EN
  logic [4:0] fwdAddr [2];

  assign fwdAddr[0] = fwd_addrA;
  assign fwdAddr[1] = fwd_addrB;

  generate
    for (gi = 0; gi < 2; gi++) begin : gFwd
      logic            hit;
      logic [XLEN-1:0] data;

      // The scan starts at the output register and then walks from oldest to youngest, so the youngest match wins.
      always_comb begin
        hit  = 1'b0;
        data = '0;
        if (regwen && (addrD == fwdAddr[gi])) begin
          hit  = 1'b1;
          data = dataD;
        end
        for (int k = 0; k < DEPTH; k++) begin
          if (ageValid[k] && (rdMem[ageIdx[k]] == fwdAddr[gi])) begin
            hit  = 1'b1;
            data = dataMem[ageIdx[k]];
          end
        end
        if (fwdAddr[gi] == 5'd0) begin
          hit  = 1'b0;
          data = '0;
        end
      end
    end
  endgenerate

  assign fwd_hitA  = gFwd[0].hit;
  assign fwd_dataA = gFwd[0].data;
  assign fwd_hitB  = gFwd[1].hit;
  assign fwd_dataB = gFwd[1].data;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed testbench for reg_writeback_queue.
// It covers reset, single and dual pushes, the rd==0 case, a fill test
// with a scoreboard, reset in mid-operation, and forwarding (WB_FORWARD_EN builds only).

module tb_reg_writeback_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int NITEMS = 20;

  logic            clk;
  logic            rst_n;
  logic            mem_valid;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            regwen;
  logic [4:0]      addrD;
  logic [XLEN-1:0] dataD;
  logic [31:0]     pending;
`ifdef WB_FORWARD_EN
  logic [4:0]      fwd_addrA;
  logic [4:0]      fwd_addrB;
  logic            fwd_hitA;
  logic            fwd_hitB;
  logic [XLEN-1:0] fwd_dataA;
  logic [XLEN-1:0] fwd_dataB;
`endif

  reg_writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .regwen    (regwen),
    .addrD     (addrD),
    .dataD     (dataD),
`ifdef WB_FORWARD_EN
    .fwd_addrA (fwd_addrA),
    .fwd_addrB (fwd_addrB),
    .fwd_hitA  (fwd_hitA),
    .fwd_hitB  (fwd_hitB),
    .fwd_dataA (fwd_dataA),
    .fwd_dataB (fwd_dataB),
`endif
    .pending   (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wbEntry;

  int checksTotal  = 0;
  int checksPassed = 0;

  wbEntry items [NITEMS];
  wbEntry sbQ [$];
  wbEntry popped;
  logic [1:0] pattern [8] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b10, 2'b11, 2'b00};

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksTotal++;
    if (observed === expected) begin
      checksPassed++;
    end else begin
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock edge and sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    mem_valid = 1'b0;
    mem_rd    = 5'd0;
    mem_data  = '0;
    alu_valid = 1'b0;
    alu_rd    = 5'd0;
    alu_data  = '0;
  endtask

  initial begin
    int idx;
    int cyc;
    int aluIt;
    int freeCnt;
    logic mv, av, expM, expA, accM, accA, hadPop;
    logic [31:0] expPend;

    // ---------------- reset with both valids high ----------------
    rst_n     = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd9;  mem_data = 32'h9999;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hAAAA;
`ifdef WB_FORWARD_EN
    fwd_addrA = 5'd0;
    fwd_addrB = 5'd0;
`endif
    step();
    step();
    checkVal("rst_mem_ready", mem_ready, 0);
    checkVal("rst_alu_ready", alu_ready, 0);
    checkVal("rst_regwen", regwen, 0);
    checkVal("rst_addrD", addrD, 0);
    checkVal("rst_dataD", dataD, 0);
    checkVal("rst_pending", pending, 0);
    idleInputs();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkVal("post_rst_regwen", regwen, 0);
    end
    $display("txn reset done");

    // ---------------- single ALU result ----------------
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    #1;
    checkVal("single_alu_ready", alu_ready, 1);
    step();
    idleInputs();
    checkVal("single_regwen_n", regwen, 0);
    checkVal("single_pend_q", pending, 32'h20);
    step();
    checkVal("single_regwen", regwen, 1);
    checkVal("single_addrD", addrD, 5);
    checkVal("single_dataD", dataD, 32'h1234);
    checkVal("single_pend_o", pending, 32'h20);
    step();
    checkVal("single_regwen_off", regwen, 0);
    checkVal("single_pend_clr", pending, 0);
    $display("txn single alu rd=5 data=0x1234");

    // ---------------- both valid in one cycle ----------------
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hAAAA;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hBBBB;
    #1;
    checkVal("dual_mem_ready", mem_ready, 1);
    checkVal("dual_alu_ready", alu_ready, 1);
    step();
    idleInputs();
    checkVal("dual_pend_q", pending, 32'h18);
    step();
    checkVal("dual_w1_regwen", regwen, 1);
    checkVal("dual_w1_addrD", addrD, 3);
    checkVal("dual_w1_dataD", dataD, 32'hAAAA);
    checkVal("dual_w1_pend", pending, 32'h18);
    step();
    checkVal("dual_w2_regwen", regwen, 1);
    checkVal("dual_w2_addrD", addrD, 4);
    checkVal("dual_w2_dataD", dataD, 32'hBBBB);
    checkVal("dual_w2_pend", pending, 32'h10);
    step();
    checkVal("dual_regwen_off", regwen, 0);
    checkVal("dual_pend_clr", pending, 0);
    $display("txn dual mem rd=3 then alu rd=4");

    // ---------------- rd == 0 push ----------------
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    #1;
    checkVal("rd0_alu_ready", alu_ready, 1);
    step();
    idleInputs();
    checkVal("rd0_pend", pending, 0);
    checkVal("rd0_regwen_a", regwen, 0);
    step();
    checkVal("rd0_regwen_b", regwen, 0);
    checkVal("rd0_addrD_hold", addrD, 4);
    checkVal("rd0_dataD_hold", dataD, 32'hBBBB);
    step();
    checkVal("rd0_regwen_c", regwen, 0);
    $display("txn rd0 push discarded");

    // ---------------- fill / back-to-back with scoreboard ----------------
    for (int i = 0; i < NITEMS; i++) begin
      items[i].rd   = 5'($urandom_range(1, 31));
      items[i].data = $urandom;
    end
    idx = 0;
    cyc = 0;
    while ((idx < NITEMS || sbQ.size() > 0) && cyc < 200) begin
      mv = pattern[cyc % 8][1] && (idx < NITEMS);
      aluIt = mv ? idx + 1 : idx;
      av = pattern[cyc % 8][0] && (aluIt < NITEMS);
      mem_valid = mv;
      alu_valid = av;
      if (mv) begin
        mem_rd = items[idx].rd; mem_data = items[idx].data;
      end
      if (av) begin
        alu_rd = items[aluIt].rd; alu_data = items[aluIt].data;
      end
      #1;
      freeCnt = DEPTH - sbQ.size();
      expM = (freeCnt >= 1);
      expA = mv ? (freeCnt >= 2) : (freeCnt >= 1);
      checkVal("fill_mem_ready", mem_ready, expM);
      checkVal("fill_alu_ready", alu_ready, expA);
      accM = mv && expM;
      accA = av && expA;
      step();
      hadPop = (sbQ.size() > 0);
      if (hadPop) popped = sbQ.pop_front();
      if (accM) sbQ.push_back(items[idx]);
      if (accA) sbQ.push_back(items[aluIt]);
      idx = idx + int'(accM) + int'(accA);
      checkVal("fill_regwen", regwen, hadPop);
      if (hadPop) begin
        checkVal("fill_addrD", addrD, popped.rd);
        checkVal("fill_dataD", dataD, popped.data);
        $display("txn wb cycle=%0d rd=%0d data=0x%08h", cyc, addrD, dataD);
      end
      expPend = '0;
      foreach (sbQ[i]) expPend[sbQ[i].rd] = 1'b1;
      if (hadPop) expPend[popped.rd] = 1'b1;
      expPend[0] = 1'b0;
      checkVal("fill_pending", pending, expPend);
      cyc++;
    end
    idleInputs();
    checkVal("fill_drained_in_budget", cyc < 200, 1);
    step();
    checkVal("fill_idle_regwen", regwen, 0);
    checkVal("fill_idle_pending", pending, 0);

    // ---------------- reset mid-operation ----------------
    mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h22;
    step();
    idleInputs();
    checkVal("midrst_pend_q", pending, 32'h1800);
    rst_n = 1'b0;
    #1;
    checkVal("midrst_mem_ready", mem_ready, 0);
    checkVal("midrst_alu_ready", alu_ready, 0);
    step();
    checkVal("midrst_regwen", regwen, 0);
    checkVal("midrst_pending", pending, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checkVal("midrst_after_regwen", regwen, 0);
      checkVal("midrst_after_pend", pending, 0);
    end
    $display("txn mid-operation reset");

`ifdef WB_FORWARD_EN
    // ---------------- forwarding ----------------
    fwd_addrA = 5'd7;
    fwd_addrB = 5'd0;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h2;
    step();
    idleInputs();
    checkVal("fwd_q_hitA", fwd_hitA, 1);
    checkVal("fwd_q_dataA", fwd_dataA, 32'h2);
    checkVal("fwd_q_hitB_zero", fwd_hitB, 0);
    fwd_addrB = 5'd7;
    step();
    #1;
    checkVal("fwd_p1_hitA", fwd_hitA, 1);
    checkVal("fwd_p1_dataA", fwd_dataA, 32'h2);
    checkVal("fwd_p1_hitB", fwd_hitB, 1);
    checkVal("fwd_p1_dataB", fwd_dataB, 32'h2);
    step();
    checkVal("fwd_p2_hitA", fwd_hitA, 1);
    checkVal("fwd_p2_dataA", fwd_dataA, 32'h2);
    step();
    checkVal("fwd_done_hitA", fwd_hitA, 0);
    checkVal("fwd_done_hitB", fwd_hitB, 0);
    $display("txn forward rd=7");
`endif

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
